cu_sequencer: RTL and testbench
===============================

# cu_sequencer

Parametrised instruction sequencer for the mnpk01 SoC. It pulls an 8-bit instruction byte stream from ROM under a valid/consume handshake and decodes opcodes with their register and immediate operands. It drives register-file write and move commands with a configurable data width and register count, and has HALT and illegal-opcode handling. It sits between the program ROM/PC and the register file.

## Interface
Parameters:
- DATA_W, 8: register/immediate width; multiple of 8, range 8..32; the immediate spans NB = DATA_W/8 bytes.
- NREG, 16: number of registers, power of two, 2..256. The localparam RA_W = clog2(NREG) is derived from it.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- rom_data  in  8  byte at current PC.
- rom_valid  in  1  rom_data is valid this cycle.
- pc_inc  out  1  byte consumed this cycle; PC advances on the next edge.
- reg_addr  out  RA_W  destination register.
- reg_src  out  RA_W  source register for MOV.
- reg_wdata  out  DATA_W  write data.
- reg_we  out  1  one-cycle write strobe; the register file writes reg_wdata to reg_addr.
- reg_mov  out  1  one-cycle copy strobe; the register file copies reg_src into reg_addr.
- halted  out  1  HALT executed.
- illegal  out  1  sticky error flag.

## Operation
Opcodes (first byte):
- 0x00 NOP: 1 byte.
- 0x01 LDI r, imm: 2+NB bytes. The immediate is little-endian; byte k goes to reg_wdata[8k+7:8k].
- 0x02 MOV rd, rs: 3 bytes.
- 0x03 CLR r: 2 bytes; writes 0.
- 0x04 HALT: 1 byte.
- Any other value is illegal: it sets `illegal` and is otherwise executed as a NOP.

Register operand byte:
- Index = byte[RA_W-1:0].
- If any bit above RA_W-1 is non-zero, set `illegal`.
- The instruction still consumes all its bytes to keep the stream aligned, but its reg_we/reg_mov strobe is suppressed.

States:
- FETCH: consume the opcode, latch ir.
  - NOP/illegal → FETCH.
  - HALT → HALT.
  - Others → REG1.
- REG1: consume the byte into reg_addr.
  - LDI → DATA (byte counter = 0).
  - MOV → REG2.
  - CLR → EXEC, with reg_wdata = 0.
- REG2: consume the byte into reg_src → EXEC.
- DATA: consume the byte into lane cnt. If cnt == NB-1 → EXEC, else cnt+1.
- EXEC: no consume. Asserts reg_we (LDI/CLR) or reg_mov (MOV) unless suppressed → FETCH.
- HALT: halted=1. Never consumes, never leaves except by reset.

Handshake rules:
- pc_inc = rom_valid AND state ∈ {FETCH, REG1, REG2, DATA}. It is combinational from registered state.
- A byte is captured on the edge ending a cycle with pc_inc=1.
- With rom_valid=0 the FSM holds state and all registers unchanged. Wait states of any length are allowed in any consuming state.

Output stability and reset:
- reg_addr, reg_src and reg_wdata hold their values until overwritten by a later capture. They are stable during the EXEC strobe.
- Reset values: all outputs 0, state FETCH, ir 0, cnt 0, illegal 0.
- Reset mid-instruction discards partial operands; no strobe is issued.

## Timing
All timings assume rom_valid is held high.
- NOP: 1 cycle.
- HALT: 1 cycle, then halted=1 from the next cycle.
- CLR: 3 cycles; reg_we is high in cycle 3.
- MOV: 4 cycles.
- LDI: 3+NB cycles, i.e. 4 at DATA_W=8 and 7 at DATA_W=32.
- The strobe is high exactly one cycle, in EXEC. The next opcode fetch happens in the cycle after EXEC.
- Back-to-back instructions need no idle cycle beyond EXEC.
- `illegal` rises on the edge that captures the offending byte and stays high until reset.

## Structure
Package cu_pkg holds:
- Opcode localparams: OP_NOP, OP_LDI, OP_MOV, OP_CLR, OP_HALT.
- The state enum: S_FETCH, S_REG1, S_REG2, S_DATA, S_EXEC, S_HALT.

Immediate lane insertion is simple enough to stay inline, so the block is a single module with no sub-module.

## Test plan
- DATA_W=8, NREG=16; stream 01 03 A5 → reg_we one cycle at cycle 4, reg_addr=3, reg_wdata=0xA5; pc_inc high cycles 1–3.
- DATA_W=32; stream 01 0F 78 56 34 12 → reg_wdata=0x12345678, reg_addr=15, reg_we in cycle 7.
- Stream 02 01 02 then 03 07 → reg_mov with reg_addr=1, reg_src=2. Then reg_we with reg_addr=7, reg_wdata=0. No idle cycle between the two instructions.
- rom_valid toggled 0/1 every other cycle during an LDI → identical captured values; pc_inc is never high while rom_valid=0.
- Stream FF, then 01 13 55 with NREG=16 → illegal set at the FF capture; no reg_we for the LDI (index bit 4 set); the next opcode is decoded correctly.
- Stream 04 00 → halted=1, pc_inc stays 0 thereafter. Async rst pulse mid-LDI → all outputs 0, restart in FETCH.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared opcode and FSM state encodings for the mnpk01 instruction sequencer.
package cu_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_LDI  = 8'h01;
    localparam logic [7:0] OP_MOV  = 8'h02;
    localparam logic [7:0] OP_CLR  = 8'h03;
    localparam logic [7:0] OP_HALT = 8'h04;

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_REG1  = 3'd1;
    localparam logic [2:0] S_REG2  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_EXEC  = 3'd4;
    localparam logic [2:0] S_HALT  = 3'd5;

endpackage

// File: rtl/cu_sequencer.sv
// Byte-stream instruction sequencer: pulls opcodes/operands from ROM and
// issues one-cycle register-file write or move strobes.
module cu_sequencer
    import cu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NREG   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rom_data,
    input  logic                    rom_valid,
    output logic                    pc_inc,
    output logic [$clog2(NREG)-1:0] reg_addr,
    output logic [$clog2(NREG)-1:0] reg_src,
    output logic [DATA_W-1:0]       reg_wdata,
    output logic                    reg_we,
    output logic                    reg_mov,
    output logic                    halted,
    output logic                    illegal
);

    localparam int RA_W  = $clog2(NREG);
    localparam int NB    = DATA_W / 8;
    localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;

    logic [2:0]       state;
    logic [7:0]       ir;
    logic [CNT_W-1:0] cnt;
    logic             bad;
    logic             bad_reg;

    // Shifting by RA_W (not slicing) keeps NREG=256 legal, where no bits remain.
    assign bad_reg = |(rom_data >> RA_W);

    assign pc_inc  = rom_valid && (state == S_FETCH || state == S_REG1 ||
                                   state == S_REG2  || state == S_DATA);
    assign reg_we  = (state == S_EXEC) && !bad && (ir == OP_LDI || ir == OP_CLR);
    assign reg_mov = (state == S_EXEC) && !bad && (ir == OP_MOV);
    assign halted  = (state == S_HALT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_FETCH;
            ir        <= '0;
            cnt       <= '0;
            bad       <= 1'b0;
            reg_addr  <= '0;
            reg_src   <= '0;
            reg_wdata <= '0;
            illegal   <= 1'b0;
        end else if (pc_inc) begin
            case (state)
                S_FETCH: begin
                    ir  <= rom_data;
                    bad <= 1'b0;
                    case (rom_data)
                        OP_NOP:                 state <= S_FETCH;
                        OP_LDI, OP_MOV, OP_CLR: state <= S_REG1;
                        OP_HALT:                state <= S_HALT;
                        default:                illegal <= 1'b1;
                    endcase
                end
                S_REG1: begin
                    reg_addr <= rom_data[RA_W-1:0];
                    if (bad_reg) begin
                        bad     <= 1'b1;
                        illegal <= 1'b1;
                    end
                    if (ir == OP_LDI) begin
                        cnt   <= '0;
                        state <= S_DATA;
                    end else if (ir == OP_MOV) begin
                        state <= S_REG2;
                    end else begin
                        reg_wdata <= '0;
                        state     <= S_EXEC;
                    end
                end
                S_REG2: begin
                    reg_src <= rom_data[RA_W-1:0];
                    if (bad_reg) begin
                        bad     <= 1'b1;
                        illegal <= 1'b1;
                    end
                    state <= S_EXEC;
                end
                S_DATA: begin
                    // Little-endian: byte k of the immediate lands in lane k.
                    for (int k = 0; k < NB; k++) begin
                        if (cnt == CNT_W'(k))
                            reg_wdata[8*k +: 8] <= rom_data;
                    end
                    if (cnt == CNT_W'(NB - 1))
                        state <= S_EXEC;
                    else
                        cnt <= cnt + 1'b1;
                end
                default: state <= state;
            endcase
        end else if (state == S_EXEC) begin
            state <= S_FETCH;
        end
    end

endmodule

// File: tb/tb_cu_sequencer.sv
// Randomised and directed check of cu_sequencer at DATA_W=8 and DATA_W=32
// against an instruction-level byte-stream model.
module tb_cu_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rd [2];
    logic       rv [2];

    logic       o_pc [2];
    logic       o_we [2];
    logic       o_mov[2];
    logic       o_h  [2];
    logic       o_il [2];
    logic [3:0] o_a  [2];
    logic [3:0] o_s  [2];
    logic [7:0]  w0;
    logic [31:0] w1;

    always #5 clk = ~clk;

    cu_sequencer #(.DATA_W(8), .NREG(16)) dut0 (
        .clk(clk), .rst(rst), .rom_data(rd[0]), .rom_valid(rv[0]),
        .pc_inc(o_pc[0]), .reg_addr(o_a[0]), .reg_src(o_s[0]), .reg_wdata(w0),
        .reg_we(o_we[0]), .reg_mov(o_mov[0]), .halted(o_h[0]), .illegal(o_il[0])
    );

    cu_sequencer #(.DATA_W(32), .NREG(16)) dut1 (
        .clk(clk), .rst(rst), .rom_data(rd[1]), .rom_valid(rv[1]),
        .pc_inc(o_pc[1]), .reg_addr(o_a[1]), .reg_src(o_s[1]), .reg_wdata(w1),
        .reg_we(o_we[1]), .reg_mov(o_mov[1]), .halted(o_h[1]), .illegal(o_il[1])
    );

    int nb[2] = '{1, 4};

    // Byte stream per instance and the bytes of the instruction in flight.
    logic [7:0] sq[2][4096];
    int         hd[2], tl[2];
    logic [7:0] ib[2][8];
    int         ibn[2];

    logic        m_exec[2], m_halt[2], m_ill[2], m_we[2], m_mov[2];
    logic [3:0]  m_addr[2], m_src[2];
    logic [31:0] m_data[2];

    int          we_cyc[2], mov_cyc[2];
    logic [3:0]  we_addr[2], mov_addr[2], mov_src[2];
    logic [31:0] we_data[2];

    int checks = 0, errors = 0, cyc = 0, vmode = 0;

    function automatic logic [31:0] wd(int i);
        return (i == 0) ? {24'h0, w0} : w1;
    endfunction

    function automatic int ilen(int i, logic [7:0] op);
        case (op)
            8'h01:   return 2 + nb[i];
            8'h02:   return 3;
            8'h03:   return 2;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] cyc=%0d actual=%0h required=%0h", nm, i, cyc, act, exp);
        end
    endtask

    task automatic push(input int i, input logic [7:0] b);
        sq[i][tl[i]] = b;
        tl[i]++;
    endtask

    task automatic clear_records();
        for (int i = 0; i < 2; i++) begin
            we_cyc[i] = -1;
            mov_cyc[i] = -1;
        end
        cyc = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            hd[i] = 0; tl[i] = 0; ibn[i] = 0;
            m_exec[i] = 0; m_halt[i] = 0; m_ill[i] = 0; m_we[i] = 0; m_mov[i] = 0;
            m_addr[i] = 0; m_src[i] = 0; m_data[i] = 0;
        end
    endtask

    task automatic compare(input int i);
        logic       cons, bad;
        logic [7:0] b, op;
        cons = rv[i] && !m_halt[i] && !m_exec[i];
        chk("pc_inc", i, o_pc[i], cons);
        chk("reg_we", i, o_we[i], m_exec[i] && m_we[i]);
        chk("reg_mov", i, o_mov[i], m_exec[i] && m_mov[i]);
        chk("halted", i, o_h[i], m_halt[i]);
        chk("illegal", i, o_il[i], m_ill[i]);
        if (m_exec[i]) begin
            chk("reg_addr", i, o_a[i], m_addr[i]);
            if (m_mov[i]) chk("reg_src", i, o_s[i], m_src[i]);
            if (m_we[i])  chk("reg_wdata", i, wd(i), m_data[i]);
        end
        if (o_we[i] && we_cyc[i] < 0) begin
            we_cyc[i] = cyc; we_addr[i] = o_a[i]; we_data[i] = wd(i);
        end
        if (o_mov[i] && mov_cyc[i] < 0) begin
            mov_cyc[i] = cyc; mov_addr[i] = o_a[i]; mov_src[i] = o_s[i];
        end
        if (m_exec[i]) begin
            m_exec[i] = 0;
        end else if (cons) begin
            b = rd[i];
            hd[i]++;
            ib[i][ibn[i]] = b;
            ibn[i]++;
            op = ib[i][0];
            if (ibn[i] == 1 && op > 8'h04) m_ill[i] = 1;
            if (op >= 8'h01 && op <= 8'h03 && (ibn[i] == 2 || (ibn[i] == 3 && op == 8'h02))
                && b[7:4] != 4'h0)
                m_ill[i] = 1;
            if (ibn[i] == ilen(i, op)) begin
                ibn[i] = 0;
                if (op == 8'h04) begin
                    m_halt[i] = 1;
                end else if (op >= 8'h01 && op <= 8'h03) begin
                    bad = (ib[i][1][7:4] != 4'h0) || (op == 8'h02 && ib[i][2][7:4] != 4'h0);
                    m_exec[i] = 1;
                    m_addr[i] = ib[i][1][3:0];
                    m_we[i]   = (op != 8'h02) && !bad;
                    m_mov[i]  = (op == 8'h02) && !bad;
                    if (op == 8'h02) m_src[i] = ib[i][2][3:0];
                    if (op == 8'h03) m_data[i] = 0;
                    if (op == 8'h01) begin
                        m_data[i] = 0;
                        for (int k = 0; k < nb[i]; k++) m_data[i][8*k +: 8] = ib[i][2+k];
                    end
                end
            end
        end
    endtask

    task automatic step();
        for (int i = 0; i < 2; i++) begin
            rv[i] = (hd[i] < tl[i]) &&
                    (vmode == 0 || (vmode == 1 && cyc % 2 == 0) ||
                     (vmode == 2 && $urandom_range(0, 3) != 0));
            rd[i] = (hd[i] < tl[i]) ? sq[i][hd[i]] : 8'($urandom);
        end
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) compare(i);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Asynchronous pulse placed mid-cycle, away from either clock edge.
    task automatic do_reset();
        rv[0] = 0; rv[1] = 0;
        #2 rst = 1'b1;
        model_reset();
        #2;
        for (int i = 0; i < 2; i++) begin
            chk("rst_pc_inc", i, o_pc[i], 0);
            chk("rst_reg_we", i, o_we[i], 0);
            chk("rst_reg_mov", i, o_mov[i], 0);
            chk("rst_halted", i, o_h[i], 0);
            chk("rst_illegal", i, o_il[i], 0);
            chk("rst_reg_addr", i, o_a[i], 0);
            chk("rst_reg_src", i, o_s[i], 0);
            chk("rst_reg_wdata", i, wd(i), 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        clear_records();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        rv[0] = 0; rv[1] = 0; rd[0] = 0; rd[1] = 0;
        model_reset();
        clear_records();
        @(posedge clk);
        #1;
        do_reset();

        // LDI at both widths
        vmode = 0;
        push(0, 8'h01); push(0, 8'h03); push(0, 8'hA5);
        push(1, 8'h01); push(1, 8'h0F); push(1, 8'h78); push(1, 8'h56); push(1, 8'h34); push(1, 8'h12);
        run(9);
        chk("ldi8_cycle", 0, we_cyc[0], 4);
        chk("ldi8_addr", 0, we_addr[0], 3);
        chk("ldi8_data", 0, we_data[0], 32'hA5);
        chk("ldi32_cycle", 1, we_cyc[1], 7);
        chk("ldi32_addr", 1, we_addr[1], 15);
        chk("ldi32_data", 1, we_data[1], 32'h12345678);

        // MOV followed immediately by CLR
        do_reset();
        push(0, 8'h02); push(0, 8'h01); push(0, 8'h02); push(0, 8'h03); push(0, 8'h07);
        run(9);
        chk("mov_cycle", 0, mov_cyc[0], 4);
        chk("mov_addr", 0, mov_addr[0], 1);
        chk("mov_src", 0, mov_src[0], 2);
        chk("clr_cycle", 0, we_cyc[0], 7);
        chk("clr_addr", 0, we_addr[0], 7);
        chk("clr_data", 0, we_data[0], 0);

        // Alternating rom_valid during LDI
        do_reset();
        vmode = 1;
        push(0, 8'h01); push(0, 8'h03); push(0, 8'hA5);
        push(1, 8'h01); push(1, 8'h0F); push(1, 8'h78); push(1, 8'h56); push(1, 8'h34); push(1, 8'h12);
        run(20);
        chk("wait_ldi8_data", 0, we_data[0], 32'hA5);
        chk("wait_ldi32_data", 1, we_data[1], 32'h12345678);

        // Illegal opcode, then LDI with out-of-range register, then CLR
        do_reset();
        vmode = 0;
        push(0, 8'hFF); push(0, 8'h01); push(0, 8'h13); push(0, 8'h55); push(0, 8'h03); push(0, 8'h02);
        run(12);
        chk("ill_sticky", 0, o_il[0], 1);
        chk("ill_next_cycle", 0, we_cyc[0], 8);
        chk("ill_next_addr", 0, we_addr[0], 2);

        // Reset in the middle of an LDI
        do_reset();
        push(0, 8'h01); push(0, 8'h03); push(0, 8'hA5);
        run(2);
        do_reset();
        push(0, 8'h01); push(0, 8'h05); push(0, 8'h3C);
        run(6);
        chk("rst_ldi_cycle", 0, we_cyc[0], 4);
        chk("rst_ldi_addr", 0, we_addr[0], 5);
        chk("rst_ldi_data", 0, we_data[0], 32'h3C);

        // Random instruction streams with random wait states
        do_reset();
        vmode = 2;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 300; k++) begin
                int r, nop;
                r = $urandom_range(0, 9);
                if (r <= 1)      push(i, 8'h00);
                else if (r == 9) push(i, 8'($urandom_range(5, 255)));
                else begin
                    nop = (r <= 4) ? 1 : (r <= 6) ? 2 : 3;
                    push(i, 8'(nop));
                    push(i, ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15)));
                    if (nop == 2)
                        push(i, ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15)));
                    if (nop == 1)
                        for (int b = 0; b < nb[i]; b++) push(i, 8'($urandom));
                end
            end
        end
        n = 0;
        while ((hd[0] < tl[0] || hd[1] < tl[1]) && n < 20000) begin
            step();
            n++;
        end
        chk("drain_timeout", 0, (n >= 20000) ? 1 : 0, 0);
        run(4);

        // HALT stops consumption for good
        vmode = 0;
        for (int i = 0; i < 2; i++) begin
            push(i, 8'h04); push(i, 8'h00);
        end
        run(8);
        chk("halt_state", 0, o_h[0], 1);
        chk("halt_state", 1, o_h[1], 1);
        chk("halt_pc_inc", 0, o_pc[0], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
